// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst beat-address generator: expands one AxADDR/AxLEN/AxSIZE/AxBURST request into per-beat addresses.
// Optional 4 KB page-crossing error check for INCR bursts enabled by defining AXI4_BURST_4K_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a request, ax_ready=1, no beat presented
// BURST | presenting beats, b_valid=1; ax_ready=1 only during the accepted last beat
module axi4_burst_addr_gen #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ax_valid,
    output logic          ax_ready,
    input  logic [AW-1:0] ax_addr,
    input  logic [7:0]    ax_len,
    input  logic [2:0]    ax_size,
    input  logic [1:0]    ax_burst,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [AW-1:0] b_addr,
    output logic          b_last,
    output logic [1:0]    b_resp
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0]  BT_FIXED    = 2'b00;
    localparam logic [1:0]  BT_INCR     = 2'b01;
    localparam logic [1:0]  BT_WRAP     = 2'b10;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [10:0] BUS_BYTES   = 11'(DW / 8);

    state_t        state, state_nxt;
    logic          accept, beat_done;
    logic [7:0]    cnt;
    logic [1:0]    burst_r;
    logic [AW-1:0] bytes_r, base_r, wmask_r;

    logic [AW-1:0] req_bytes, req_span, req_base;
    logic          req_err;
    logic [AW-1:0] incr_addr, wrap_off, next_addr;

    assign req_bytes = AW'(1) << ax_size;
    assign req_span  = (AW'(ax_len) + AW'(1)) << ax_size;
    assign req_base  = ax_addr & ~(req_span - AW'(1));

`ifdef AXI4_BURST_4K_CHECK_EN
    logic [AW-1:0] req_last;
    assign req_last = (ax_addr & ~(req_bytes - AW'(1))) + req_span - AW'(1);
`endif

    always_comb begin
        req_err = 1'b0;
        if (ax_burst == 2'b11)
            req_err = 1'b1;
        if ((11'(1) << ax_size) > BUS_BYTES)
            req_err = 1'b1;
        if (ax_burst == BT_WRAP) begin
            if (!(ax_len == 8'd1 || ax_len == 8'd3 || ax_len == 8'd7 || ax_len == 8'd15))
                req_err = 1'b1;
            if ((ax_addr & (req_bytes - AW'(1))) != '0)
                req_err = 1'b1;
        end
`ifdef AXI4_BURST_4K_CHECK_EN
        if (ax_burst == BT_INCR && req_last[AW-1:12] != ax_addr[AW-1:12])
            req_err = 1'b1;
`endif
    end

    // Wrap offset is masked with span-1; span is a power of two for every legal WRAP burst.
    always_comb begin
        incr_addr = (b_addr & ~(bytes_r - AW'(1))) + bytes_r;
        wrap_off  = (b_addr + bytes_r - base_r) & wmask_r;
        case (burst_r)
            BT_FIXED: next_addr = b_addr;
            BT_WRAP:  next_addr = base_r + wrap_off;
            default:  next_addr = incr_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ax_ready  = 1'b0;
        b_valid   = 1'b0;
        case (state)
            IDLE: begin
                ax_ready = 1'b1;
                if (ax_valid)
                    state_nxt = BURST;
            end
            BURST: begin
                b_valid = 1'b1;
                if (b_ready && b_last) begin
                    ax_ready = 1'b1;
                    if (!ax_valid)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst)
            ax_ready = 1'b0;
    end

    assign accept    = ax_valid && ax_ready;
    assign beat_done = b_valid && b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            burst_r <= BT_FIXED;
            bytes_r <= '0;
            base_r  <= '0;
            wmask_r <= '0;
            b_addr  <= '0;
            b_last  <= 1'b0;
            b_resp  <= RESP_OKAY;
        end else if (accept) begin
            cnt     <= ax_len;
            burst_r <= ax_burst;
            bytes_r <= req_bytes;
            base_r  <= req_base;
            wmask_r <= req_span - AW'(1);
            b_addr  <= ax_addr;
            b_last  <= (ax_len == 8'd0);
            b_resp  <= req_err ? RESP_SLVERR : RESP_OKAY;
        end else if (beat_done) begin
            if (b_last) begin
                b_last <= 1'b0;
            end else begin
                cnt    <= cnt - 8'd1;
                b_last <= (cnt == 8'd1);
                b_addr <= next_addr;
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Bench for axi4_burst_addr_gen: directed vectors plus randomized bursts against a queue-based reference model.
module tb_axi4_burst_addr_gen;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ax_valid = 1'b0;
    logic          ax_ready;
    logic [AW-1:0] ax_addr = '0;
    logic [7:0]    ax_len = '0;
    logic [2:0]    ax_size = '0;
    logic [1:0]    ax_burst = '0;
    logic          b_valid;
    logic          b_ready = 1'b0;
    logic [AW-1:0] b_addr;
    logic          b_last;
    logic [1:0]    b_resp;

    axi4_burst_addr_gen #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ax_valid(ax_valid), .ax_ready(ax_ready),
        .ax_addr(ax_addr), .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_addr(b_addr), .b_last(b_last), .b_resp(b_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          last;
        logic [1:0]  resp;
        bit          chk_addr;
    } beat_t;

    beat_t       expq[$];
    logic [31:0] seen_addr[$];
    logic [1:0]  seen_resp[$];
    bit          seen_last[$];

    int n_chk = 0;
    int n_pass = 0;
    int rdy_mode = 0;
    int pidx = 0;
    bit mon_en = 1'b0;
    int beats_seen = 0;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: beat list from the burst rules, in unbounded arithmetic.
    task automatic push_expected(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                 input logic [1:0] bt);
        longint unsigned bytes, n, span, base, cur;
        bit err;
        beat_t e;
        bytes = 64'd1 << s;
        n     = longint'(l) + 1;
        span  = bytes * n;
        err   = 1'b0;
        if (bt == 2'b11) err = 1'b1;
        if (bytes > DW / 8) err = 1'b1;
        if (bt == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16)) err = 1'b1;
        if (bt == 2'b10 && (a % bytes) != 0) err = 1'b1;
`ifdef AXI4_BURST_4K_CHECK_EN
        if (bt == 2'b01 && ((a - a % bytes + span - 1) / 4096) != (a / 4096)) err = 1'b1;
`endif
        base = a - (a % span);
        cur  = a;
        for (longint unsigned i = 0; i < n; i++) begin
            e.addr     = cur[31:0];
            e.last     = (i == n - 1);
            e.resp     = err ? 2'b10 : 2'b00;
            e.chk_addr = !err || i == 0;
            expq.push_back(e);
            case (bt)
                2'b01:   cur = (cur - cur % bytes + bytes) % (64'd1 << 32);
                2'b10:   cur = base + (cur + bytes - base) % span;
                default: cur = cur;
            endcase
        end
    endtask

    // Beat monitor and b_ready driver.
    initial begin
        bit          prev_stall;
        logic [31:0] hold_addr;
        logic        hold_last;
        logic [1:0]  hold_resp;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (b_valid) begin
                    check("beat_expected", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        if (expq[0].chk_addr) check("b_addr", b_addr, expq[0].addr);
                        check("b_last", b_last, expq[0].last);
                        check("b_resp", b_resp, expq[0].resp);
                    end
                    if (prev_stall) begin
                        check("stall_addr", b_addr, hold_addr);
                        check("stall_last", b_last, hold_last);
                        check("stall_resp", b_resp, hold_resp);
                    end
                end
                case (rdy_mode)
                    0: b_ready = 1'b1;
                    1: b_ready = ($urandom_range(0, 3) != 0);
                    default: begin
                        b_ready = b_valid ? (pidx % 2 == 0) : 1'b1;
                        if (b_valid) pidx++;
                    end
                endcase
                prev_stall = b_valid && !b_ready;
                hold_addr  = b_addr;
                hold_last  = b_last;
                hold_resp  = b_resp;
                if (b_valid && b_ready) begin
                    seen_addr.push_back(b_addr);
                    seen_resp.push_back(b_resp);
                    seen_last.push_back(b_last);
                    if (expq.size() > 0) void'(expq.pop_front());
                    beats_seen++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [1:0] bt, output bit in_last);
        int n = 0;
        @(negedge clk); #2;
        ax_addr = a; ax_len = l; ax_size = s; ax_burst = bt; ax_valid = 1'b1;
        while (!ax_ready && n < 300) begin
            @(negedge clk); #2;
            n++;
        end
        check("ax_accept_in_time", n < 300, 1);
        in_last = b_valid && b_last;
        push_expected(a, l, s, bt);
        @(posedge clk); #1;
        ax_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk); #3;
        while ((expq.size() != 0 || b_valid) && n < 2000) begin
            @(negedge clk); #3;
            n++;
        end
        check("drain_in_time", n < 2000, 1);
    endtask

    task automatic clear_seen();
        seen_addr.delete();
        seen_resp.delete();
        seen_last.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          il;
        logic [31:0] v31[4];
        logic [31:0] v32[4];
        logic [31:0] v36[4];
        int          n, b0;
        v31 = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
        v32 = '{32'h38, 32'h3C, 32'h30, 32'h34};
        v36 = '{32'h0FF8, 32'h0FFC, 32'h1000, 32'h1004};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_b_valid", b_valid, 0);
        check("rst_ax_ready", ax_ready, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_b_last", b_last, 0);
        check("rst_b_resp", b_resp, 0);
        #1 rst = 1'b0;
        #1 check("ax_ready_after_rst", ax_ready, 1);
        mon_en = 1'b1;

        rdy_mode = 0;
        clear_seen();
        send(32'h1002, 8'd3, 3'd2, 2'b01, il);
        drain();
        check("incr_beats", seen_addr.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
            check("incr_addr", seen_addr[i], v31[i]);
            check("incr_last", seen_last[i], i == 3);
            check("incr_resp", seen_resp[i], 0);
        end

        clear_seen();
        send(32'h38, 8'd3, 3'd2, 2'b10, il);
        drain();
        check("wrap_beats", seen_addr.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
            check("wrap_addr", seen_addr[i], v32[i]);
            check("wrap_last", seen_last[i], i == 3);
            check("wrap_resp", seen_resp[i], 0);
        end

        rdy_mode = 2;
        pidx = 0;
        clear_seen();
        send(32'h2000, 8'd2, 3'd2, 2'b00, il);
        drain();
        check("fixed_beats", seen_addr.size(), 3);
        for (int i = 0; i < seen_addr.size(); i++)
            check("fixed_addr", seen_addr[i], 32'h2000);

        rdy_mode = 0;
        send(32'h100, 8'd0, 3'd2, 2'b01, il);
        send(32'h200, 8'd1, 3'd2, 2'b01, il);
        check("b2b_ready_in_last", il, 1);
        check("b2b_nogap_valid", b_valid, 1);
        check("b2b_nogap_addr", b_addr, 32'h200);
        drain();

        clear_seen();
        send(32'h40, 8'd1, 3'd2, 2'b11, il);
        send(32'h40, 8'd2, 3'd2, 2'b10, il);
        send(32'h40, 8'd0, 3'd3, 2'b01, il);
        drain();
        check("err_beats", seen_resp.size(), 6);
        for (int i = 0; i < seen_resp.size(); i++)
            check("err_resp", seen_resp[i], 2'b10);
        if (seen_addr.size() > 0) check("err_beat0_addr", seen_addr[0], 32'h40);

        clear_seen();
        send(32'h0FF8, 8'd3, 3'd2, 2'b01, il);
        drain();
        check("4k_beats", seen_addr.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
`ifdef AXI4_BURST_4K_CHECK_EN
            check("4k_resp", seen_resp[i], 2'b10);
`else
            check("4k_addr", seen_addr[i], v36[i]);
            check("4k_resp", seen_resp[i], 0);
`endif
        end

        b0 = beats_seen;
        send(32'h3000, 8'd7, 3'd2, 2'b01, il);
        n = 0;
        while (beats_seen < b0 + 2 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        check("midrst_reach_beat2", n < 100, 1);
        rst = 1'b1;
        mon_en = 1'b0;
        expq.delete();
        @(posedge clk);
        @(negedge clk); #1;
        check("midrst_b_valid", b_valid, 0);
        check("midrst_ax_ready", ax_ready, 0);
        check("midrst_b_last", b_last, 0);
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        #1 check("midrst_ready_after", ax_ready, 1);
        send(32'h500, 8'd1, 3'd2, 2'b01, il);
        drain();

        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [2:0]  s;
            logic [1:0]  bt;
            a  = $urandom;
            s  = 3'($urandom_range(0, 3));
            bt = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0)
                a = a & ~((32'd1 << s) - 32'd1);
            send(a, 8'($urandom_range(0, 15)), s, bt, il);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi4_burst_addr_gen.md
AXI4_BURST_ADDR_GEN -- requirements
Module: axi4_burst_addr_gen

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data bus width in bits; a power of two, 8..1024.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ax_valid  input  1  address-channel request valid.
REQ-006 ax_ready  output  1  address-channel request accepted.
REQ-007 ax_addr  input  AW  burst start address (AxADDR).
REQ-008 ax_len  input  8  AxLEN; beats = ax_len+1.
REQ-009 ax_size  input  3  AxSIZE; bytes per beat = 1<<ax_size.
REQ-010 ax_burst  input  2  AxBURST: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 b_valid  output  1  beat address valid.
REQ-012 b_ready  input  1  downstream accepts beat.
REQ-013 b_addr  output  AW  current beat address.
REQ-014 b_last  output  1  final beat of burst.
REQ-015 b_resp  output  2  OKAY=00 or SLVERR=10 for the whole burst.

Function
REQ-016 The FSM SHALL have two states, IDLE and BURST.
- IDLE: ax_ready=1, b_valid=0.
- BURST: b_valid=1.
REQ-017 On ax_valid&&ax_ready, the block SHALL latch the request, load the beat counter with ax_len, and present beat 0 on the next cycle with b_addr=ax_addr.
REQ-018 A beat SHALL advance only on b_valid&&b_ready; b_addr, b_last and b_resp SHALL hold stable while b_valid&&!b_ready.
REQ-019 b_last SHALL be 1 when the remaining-beat counter equals 0; ax_len=0 gives a single beat with b_last=1.
REQ-020 ax_ready SHALL also be 1 in BURST during the cycle b_valid&&b_ready&&b_last. A request accepted in that cycle SHALL start a new burst with no idle bubble; otherwise the FSM SHALL return to IDLE.
REQ-021 FIXED: every beat address SHALL equal ax_addr.
REQ-022 INCR: next address SHALL be (addr & ~(bytes-1)) + bytes, computed modulo 2^AW.
REQ-023 WRAP: with span = bytes*(ax_len+1) and base = ax_addr & ~(span-1), next address SHALL be base + ((addr+bytes-base) mod span).
REQ-024 b_resp SHALL be SLVERR (10) for every beat of the burst if any of these hold:
- ax_burst=11;
- (1<<ax_size) > DW/8;
- WRAP with ax_len not in {1,3,7,15};
- WRAP with ax_addr not aligned to bytes.
Otherwise b_resp SHALL be OKAY (00).
REQ-025 An errored burst SHALL still emit ax_len+1 beats, so that data-channel beat counts stay consistent.
REQ-026 For errored bursts, the address sequence is don't-care except that b_addr of beat 0 SHALL equal ax_addr.
REQ-027 Output registers SHALL drive b_addr, b_last and b_resp; there is no combinational path from b_ready to b_addr.

Reset
REQ-028 While rst=1 at a clk edge, the block SHALL enter IDLE and drive b_valid=0, b_last=0, b_addr=0, b_resp=00, ax_ready=0. ax_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no further beats issued; the first request after reset starts cleanly.

Configuration
REQ-030 Macro AXI4_BURST_4K_CHECK_EN:
- When defined: an INCR burst whose last byte (aligned start + bytes*(ax_len+1) - 1) lies in a different 4 KB page from ax_addr SHALL get b_resp=SLVERR on all beats.
- When undefined: no 4 KB check is made and such bursts return OKAY.

Verification
REQ-031 INCR, addr=0x1002, size=2, len=3, b_ready=1 -> b_addr 0x1002, 0x1004, 0x1008, 0x100C; b_last only on beat 4; resp OKAY.
REQ-032 WRAP, addr=0x0038, size=2, len=3 -> 0x38, 0x3C, 0x30, 0x34; last on 0x34; resp OKAY.
REQ-033 FIXED, addr=0x2000, len=2, b_ready toggling 1,0,1,0,1 -> three beats at 0x2000; outputs stable during stall cycles.
REQ-034 Back-to-back: second request valid during the last beat of INCR len=0 -> ax_ready=1 that cycle; second burst's beat 0 valid on the next cycle with no gap.
REQ-035 Errors:
- ax_burst=11, len=1 -> 2 beats, both SLVERR;
- WRAP len=2 -> 3 beats, SLVERR;
- size=3 with DW=32 -> SLVERR.
REQ-036 4 KB check, INCR addr=0x0FF8, size=2, len=3:
- with AXI4_BURST_4K_CHECK_EN -> SLVERR on all 4 beats;
- without it -> OKAY, addresses 0x0FF8, 0x0FFC, 0x1000, 0x1004.
A separate case asserts rst during beat 2 -> b_valid=0 on the next cycle.
